// File: rtl/dest_ip_tbl_arbiter_pkg.sv
// Shared types for the destination-IP table arbiter: FSM states, op encoding, default timeout.
package dest_ip_tbl_arbiter_pkg;

  localparam int DEF_TIMEOUT_CYCLES = 16;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    DONE,
    SWEEP_ISSUE,
    SWEEP_WAIT
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

endpackage

// File: rtl/dest_ip_tbl_arbiter_rr_arb2.sv
// Two-way round-robin grant: combinational grant, registered last-grant pointer.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic last_q, last_d;

  always_comb begin
    gnt    = req;
    // With both pending, favour the requester that was not served last.
    if (req == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
    last_d = last_q;
    if (accept && (|gnt)) last_d = gnt[1];
  end

  // Pointer starts at 1 so requester 0 wins the first contended grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/dest_ip_tbl_arbiter.sv
// Serialises two requesters onto the single destination-IP table port with an ack timeout.
// Optional table clear sweep is built when DEST_IP_TBL_ARB_SWEEP_EN is defined.
module dest_ip_tbl_arbiter
  import dest_ip_tbl_arbiter_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int TBL_ADDR_WIDTH     = 5,
  parameter int TIMEOUT_CYCLES     = DEF_TIMEOUT_CYCLES
) (
  input  logic                          AXI_ACLK,
  input  logic                          AXI_RESETN,
  input  logic                          req0_rd,
  input  logic                          req0_wr,
  input  logic [TBL_ADDR_WIDTH-1:0]     req0_addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] req0_wr_data,
  output logic [C_S_AXI_DATA_WIDTH-1:0] req0_rd_data,
  output logic                          req0_ack,
  output logic                          req0_err,
  input  logic                          req1_rd,
  input  logic                          req1_wr,
  input  logic [TBL_ADDR_WIDTH-1:0]     req1_addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] req1_wr_data,
  output logic [C_S_AXI_DATA_WIDTH-1:0] req1_rd_data,
  output logic                          req1_ack,
  output logic                          req1_err,
  output logic                          tbl_rd_req,
  output logic                          tbl_wr_req,
  output logic [TBL_ADDR_WIDTH-1:0]     tbl_rd_addr,
  output logic [TBL_ADDR_WIDTH-1:0]     tbl_wr_addr,
  output logic [C_S_AXI_DATA_WIDTH-1:0] tbl_wr_data,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] tbl_rd_data,
  input  logic                          tbl_rd_ack,
  input  logic                          tbl_wr_ack,
  output logic                          busy,
  output logic [31:0]                   err_count
`ifdef DEST_IP_TBL_ARB_SWEEP_EN
  ,
  input  logic                          clear_start,
  output logic                          clear_busy
`endif
);

  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int AW    = TBL_ADDR_WIDTH;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  state_e          state_q, state_d;
  op_e             hold_op_q, hold_op_d;
  logic            hold_ill_q, hold_ill_d;
  logic            hold_id_q, hold_id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic            tbl_rd_req_q, tbl_rd_req_d, tbl_wr_req_q, tbl_wr_req_d;
  logic [AW-1:0]   tbl_rd_addr_q, tbl_rd_addr_d, tbl_wr_addr_q, tbl_wr_addr_d;
  logic [DW-1:0]   tbl_wr_data_q, tbl_wr_data_d;
  logic            req0_ack_q, req0_ack_d, req1_ack_q, req1_ack_d;
  logic            req0_err_q, req0_err_d, req1_err_q, req1_err_d;
  logic [DW-1:0]   req0_rd_data_q, req0_rd_data_d, req1_rd_data_q, req1_rd_data_d;
  logic            busy_q, busy_d;
  logic [31:0]     err_count_q, err_count_d;

  logic [1:0]      gnt;
  logic            rr_accept;
  logic            sel_rd, sel_wr;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic            done_en, done_err, err_inc;
  logic [DW-1:0]   done_data;

`ifdef DEST_IP_TBL_ARB_SWEEP_EN
  logic            sweep_pend_q, sweep_pend_d;
  logic [AW-1:0]   sweep_addr_q, sweep_addr_d;
  logic            clear_busy_q, clear_busy_d;
  logic            sweeping;
  assign sweeping = sweep_pend_q || (state_q == SWEEP_ISSUE) || (state_q == SWEEP_WAIT);
`endif

  rr_arb2 u_rr (
    .clk    (AXI_ACLK),
    .rst_n  (AXI_RESETN),
    .req    ({req1_rd | req1_wr, req0_rd | req0_wr}),
    .accept (rr_accept),
    .gnt    (gnt)
  );

  always_comb begin
    state_d        = state_q;
    hold_op_d      = hold_op_q;
    hold_ill_d     = hold_ill_q;
    hold_id_d      = hold_id_q;
    cnt_d          = cnt_q;
    tbl_rd_req_d   = 1'b0;
    tbl_wr_req_d   = 1'b0;
    tbl_rd_addr_d  = tbl_rd_addr_q;
    tbl_wr_addr_d  = tbl_wr_addr_q;
    tbl_wr_data_d  = tbl_wr_data_q;
    req0_ack_d     = 1'b0;
    req1_ack_d     = 1'b0;
    req0_err_d     = 1'b0;
    req1_err_d     = 1'b0;
    req0_rd_data_d = req0_rd_data_q;
    req1_rd_data_d = req1_rd_data_q;
    rr_accept      = 1'b0;
    done_en        = 1'b0;
    done_err       = 1'b0;
    done_data      = '0;
    err_inc        = 1'b0;
    sel_rd         = gnt[1] ? req1_rd      : req0_rd;
    sel_wr         = gnt[1] ? req1_wr      : req0_wr;
    sel_addr       = gnt[1] ? req1_addr    : req0_addr;
    sel_data       = gnt[1] ? req1_wr_data : req0_wr_data;
`ifdef DEST_IP_TBL_ARB_SWEEP_EN
    sweep_pend_d   = sweep_pend_q | (clear_start & ~sweeping);
    sweep_addr_d   = sweep_addr_q;
`endif

    case (state_q)
      IDLE: begin
`ifdef DEST_IP_TBL_ARB_SWEEP_EN
        if (sweep_pend_q) begin
          sweep_pend_d  = 1'b0;
          sweep_addr_d  = '0;
          tbl_wr_req_d  = 1'b1;
          tbl_wr_addr_d = '0;
          tbl_wr_data_d = '0;
          state_d       = SWEEP_ISSUE;
        end else
`endif
        if (|gnt) begin
          // The table-side address/data registers double as the holding registers.
          rr_accept  = 1'b1;
          hold_id_d  = gnt[1];
          hold_ill_d = sel_rd & sel_wr;
          hold_op_d  = sel_wr ? OP_WR : OP_RD;
          state_d    = ISSUE;
          if (!(sel_rd & sel_wr)) begin
            if (sel_wr) begin
              tbl_wr_req_d  = 1'b1;
              tbl_wr_addr_d = sel_addr;
              tbl_wr_data_d = sel_data;
            end else begin
              tbl_rd_req_d  = 1'b1;
              tbl_rd_addr_d = sel_addr;
            end
          end
        end
      end
      ISSUE: begin
        cnt_d = '0;
        if (hold_ill_q) begin
          done_en  = 1'b1;
          done_err = 1'b1;
        end else begin
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (hold_op_q == OP_RD && tbl_rd_ack) begin
          done_en   = 1'b1;
          done_data = tbl_rd_data;
        end else if (hold_op_q == OP_WR && tbl_wr_ack) begin
          done_en = 1'b1;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          done_en  = 1'b1;
          done_err = 1'b1;
        end
      end
      DONE: state_d = IDLE;
`ifdef DEST_IP_TBL_ARB_SWEEP_EN
      SWEEP_ISSUE: begin
        cnt_d   = '0;
        state_d = SWEEP_WAIT;
      end
      SWEEP_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (tbl_wr_ack || cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_inc = ~tbl_wr_ack;
          if (sweep_addr_q == {AW{1'b1}}) begin
            state_d = IDLE;
          end else begin
            sweep_addr_d  = sweep_addr_q + AW'(1);
            tbl_wr_req_d  = 1'b1;
            tbl_wr_addr_d = sweep_addr_q + AW'(1);
            tbl_wr_data_d = '0;
            state_d       = SWEEP_ISSUE;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (done_en) begin
      state_d = DONE;
      err_inc = done_err;
      if (hold_id_q) begin
        req1_ack_d     = 1'b1;
        req1_err_d     = done_err;
        req1_rd_data_d = done_data;
      end else begin
        req0_ack_d     = 1'b1;
        req0_err_d     = done_err;
        req0_rd_data_d = done_data;
      end
    end

    err_count_d = (err_inc && err_count_q != 32'hFFFF_FFFF) ? err_count_q + 32'd1 : err_count_q;
    busy_d      = (state_d != IDLE);
`ifdef DEST_IP_TBL_ARB_SWEEP_EN
    clear_busy_d = sweep_pend_d || (state_d == SWEEP_ISSUE) || (state_d == SWEEP_WAIT);
`endif
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      state_q        <= IDLE;
      hold_op_q      <= OP_RD;
      hold_ill_q     <= 1'b0;
      hold_id_q      <= 1'b0;
      cnt_q          <= '0;
      tbl_rd_req_q   <= 1'b0;
      tbl_wr_req_q   <= 1'b0;
      tbl_rd_addr_q  <= '0;
      tbl_wr_addr_q  <= '0;
      tbl_wr_data_q  <= '0;
      req0_ack_q     <= 1'b0;
      req1_ack_q     <= 1'b0;
      req0_err_q     <= 1'b0;
      req1_err_q     <= 1'b0;
      req0_rd_data_q <= '0;
      req1_rd_data_q <= '0;
      busy_q         <= 1'b0;
      err_count_q    <= '0;
`ifdef DEST_IP_TBL_ARB_SWEEP_EN
      sweep_pend_q   <= 1'b0;
      sweep_addr_q   <= '0;
      clear_busy_q   <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      hold_op_q      <= hold_op_d;
      hold_ill_q     <= hold_ill_d;
      hold_id_q      <= hold_id_d;
      cnt_q          <= cnt_d;
      tbl_rd_req_q   <= tbl_rd_req_d;
      tbl_wr_req_q   <= tbl_wr_req_d;
      tbl_rd_addr_q  <= tbl_rd_addr_d;
      tbl_wr_addr_q  <= tbl_wr_addr_d;
      tbl_wr_data_q  <= tbl_wr_data_d;
      req0_ack_q     <= req0_ack_d;
      req1_ack_q     <= req1_ack_d;
      req0_err_q     <= req0_err_d;
      req1_err_q     <= req1_err_d;
      req0_rd_data_q <= req0_rd_data_d;
      req1_rd_data_q <= req1_rd_data_d;
      busy_q         <= busy_d;
      err_count_q    <= err_count_d;
`ifdef DEST_IP_TBL_ARB_SWEEP_EN
      sweep_pend_q   <= sweep_pend_d;
      sweep_addr_q   <= sweep_addr_d;
      clear_busy_q   <= clear_busy_d;
`endif
    end
  end

  assign tbl_rd_req   = tbl_rd_req_q;
  assign tbl_wr_req   = tbl_wr_req_q;
  assign tbl_rd_addr  = tbl_rd_addr_q;
  assign tbl_wr_addr  = tbl_wr_addr_q;
  assign tbl_wr_data  = tbl_wr_data_q;
  assign req0_ack     = req0_ack_q;
  assign req1_ack     = req1_ack_q;
  assign req0_err     = req0_err_q;
  assign req1_err     = req1_err_q;
  assign req0_rd_data = req0_rd_data_q;
  assign req1_rd_data = req1_rd_data_q;
  assign busy         = busy_q;
  assign err_count    = err_count_q;
`ifdef DEST_IP_TBL_ARB_SWEEP_EN
  assign clear_busy   = clear_busy_q;
`endif

endmodule
